// File: rtl/ramen_order_dispatch.sv
// Order feeder for the ramen core: buffers orders in a FIFO, serialises them onto the
// core's two-cycle in_valid protocol, checks response timing and reports per-order results.
module ramen_order_dispatch #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ord_valid,
   output logic             ord_ready,
   input  logic [1:0]       ord_type,
   input  logic             ord_portion,
   input  logic             ord_last,
   input  logic [TAG_W-1:0] ord_tag,
   output logic             rm_in_valid,
   output logic [1:0]       rm_ramen_type,
   output logic             rm_portion,
   output logic             rm_selling,
   input  logic             rm_out_valid_order,
   input  logic             rm_success,
   input  logic             rm_out_valid_tot,
   output logic             res_valid,
   output logic             res_success,
   output logic [TAG_W-1:0] res_tag,
   output logic             day_done,
   output logic             proto_err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [1:0]       typ;
      logic             portion;
      logic             last;
      logic [TAG_W-1:0] tag;
   } ord_t;

   typedef enum logic [2:0] {IDLE, SEND_T, SEND_P, GAP, RESULT, TOT} state_t;

   state_t          state, state_nxt;
   ord_t            mem [DEPTH];
   ord_t            cur;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            push, pop;

   assign ord_ready = (count != FULL);
   assign push      = ord_valid && ord_ready;
   assign pop       = (state == IDLE) && (count != '0);

   // Storage needs no reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{typ: ord_type, portion: ord_portion, last: ord_last, tag: ord_tag};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = SEND_T;
         SEND_T:  state_nxt = SEND_P;
         SEND_P:  state_nxt = GAP;
         GAP:     state_nxt = RESULT;
         RESULT:  state_nxt = cur.last ? TOT : IDLE;
         TOT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Type/portion registers hold their value between orders so the core never sees X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur           <= '0;
         rm_ramen_type <= '0;
         rm_portion    <= 1'b0;
         proto_err     <= 1'b0;
      end else begin
         if (pop) begin
            cur           <= mem[rd_ptr];
            rm_ramen_type <= mem[rd_ptr].typ;
         end
         if (state == SEND_T) rm_portion <= cur.portion;
         if (((state == RESULT) != rm_out_valid_order) ||
             ((state == TOT)    != rm_out_valid_tot))
            proto_err <= 1'b1;
      end
   end

   assign rm_in_valid = (state == SEND_T) || (state == SEND_P);
   assign rm_selling  = !((state == TOT) || ((state == RESULT) && cur.last));
   assign res_valid   = (state == RESULT);
   assign res_success = (state == RESULT) && rm_out_valid_order && rm_success;
   assign res_tag     = (state == RESULT) ? cur.tag : '0;
   assign day_done    = (state == TOT);
endmodule

// File: tb/tb_ramen_order_dispatch.sv
// Directed bench for ramen_order_dispatch with a small behavioural core model
// (fixed response timing, 63-serving stock restocked at close of day).
module tb_ramen_order_dispatch;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic ord_valid, ord_ready, ord_portion, ord_last;
   logic [1:0] ord_type;
   logic [TAG_W-1:0] ord_tag;
   logic rm_in_valid, rm_portion, rm_selling;
   logic [1:0] rm_ramen_type;
   logic ovo, succ, ovt;
   logic res_valid, res_success, day_done, proto_err;
   logic [TAG_W-1:0] res_tag;

   int n_tests = 0;
   int n_fail  = 0;
   logic faulty = 1'b0;

   always #5 clk = ~clk;

   ramen_order_dispatch #(.DEPTH(4), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_type(ord_type),
      .ord_portion(ord_portion), .ord_last(ord_last), .ord_tag(ord_tag),
      .rm_in_valid(rm_in_valid), .rm_ramen_type(rm_ramen_type), .rm_portion(rm_portion),
      .rm_selling(rm_selling), .rm_out_valid_order(ovo), .rm_success(succ),
      .rm_out_valid_tot(ovt), .res_valid(res_valid), .res_success(res_success),
      .res_tag(res_tag), .day_done(day_done), .proto_err(proto_err)
   );

   // Core model: answers two cycles after the second in_valid cycle, totals one cycle after selling drops.
   logic iv_d, p1;
   int   stock;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iv_d <= 1'b0; p1 <= 1'b0; ovo <= 1'b0; succ <= 1'b0; ovt <= 1'b0; stock <= 63;
      end else begin
         iv_d <= rm_in_valid;
         p1   <= rm_in_valid && iv_d;
         ovo  <= p1 && !faulty;
         succ <= 1'b0;
         if (p1) begin
            succ <= (stock > 0);
            if (stock > 0) stock <= stock - 1;
         end
         ovt <= !rm_selling && !ovt;
         if (ovt) stock <= 63;
      end
   end

   logic [TAG_W-1:0] rq_tag [$];
   logic             rq_succ [$];
   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         rq_tag.push_back(res_tag);
         rq_succ.push_back(res_success);
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic set_ord(input logic [1:0] t, input logic p, input logic l, input logic [TAG_W-1:0] g);
      ord_type = t; ord_portion = p; ord_last = l; ord_tag = g;
   endtask

   task automatic push(input logic [1:0] t, input logic p, input logic l, input logic [TAG_W-1:0] g);
      logic hs;
      int n;
      hs = 1'b0; n = 0;
      set_ord(t, p, l, g);
      ord_valid = 1'b1;
      while (!hs && n < 100) begin
         @(negedge clk);
         hs = ord_ready;
         @(posedge clk); #1;
         n++;
      end
      ord_valid = 1'b0;
      if (!hs) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_results(input int want, input int budget);
      int n;
      n = 0;
      while (rq_tag.size() < want && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("result_count", rq_tag.size(), want);
   endtask

   initial begin
      int nxt;
      logic hs;
      logic rdy_log [12];
      int nsucc;
      ord_valid = 1'b0;
      set_ord(2'd0, 1'b0, 1'b0, '0);
      rst_n = 1'b0;
      #2;
      chk("rst_in_valid", rm_in_valid, 1'b0);
      chk("rst_selling",  rm_selling,  1'b1);
      chk("rst_ready",    ord_ready,   1'b1);
      chk("rst_res_valid", res_valid,  1'b0);
      chk("rst_day_done", day_done,    1'b0);
      chk("rst_proto",    proto_err,   1'b0);
      do_reset();

      // Single order pushed in cycle 0
      set_ord(2'd2, 1'b1, 1'b0, 4'd5);
      ord_valid = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk($sformatf("t2_in_valid_c%0d", c), rm_in_valid, (c == 2 || c == 3));
         chk($sformatf("t2_res_valid_c%0d", c), res_valid, (c == 5));
         if (c == 2) chk("t2_type", rm_ramen_type, 2'd2);
         if (c == 3) chk("t2_portion", rm_portion, 1'b1);
         if (c == 5) begin
            chk("t2_tag", res_tag, 4'd5);
            chk("t2_success", res_success, 1'b1);
         end
         @(posedge clk); #1;
         ord_valid = 1'b0;
      end

      // FIFO fill while the core is busy
      rq_tag.delete(); rq_succ.delete();
      nxt = 0;
      for (int c = 0; c < 12; c++) begin
         if (nxt < 6) begin
            set_ord(nxt[1:0], nxt[0], 1'b0, TAG_W'(nxt + 1));
            ord_valid = 1'b1;
         end else ord_valid = 1'b0;
         @(negedge clk);
         rdy_log[c] = ord_ready;
         hs = ord_ready && ord_valid;
         @(posedge clk); #1;
         if (hs) nxt++;
      end
      ord_valid = 1'b0;
      chk("t3_ready_c2", rdy_log[2], 1'b1);
      chk("t3_ready_c4", rdy_log[4], 1'b1);
      chk("t3_ready_c5", rdy_log[5], 1'b0);
      chk("t3_ready_c6", rdy_log[6], 1'b0);
      chk("t3_ready_c7", rdy_log[7], 1'b1);
      chk("t3_ready_c8", rdy_log[8], 1'b0);
      wait_results(6, 200);
      for (int i = 0; i < 6 && i < rq_tag.size(); i++)
         chk($sformatf("t3_order_%0d", i), rq_tag[i], i + 1);
      repeat (3) @(posedge clk); #1;

      // Closing order
      set_ord(2'd1, 1'b0, 1'b1, 4'd7);
      ord_valid = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         chk($sformatf("t4_selling_c%0d", c), rm_selling, !(c == 5 || c == 6));
         chk($sformatf("t4_day_done_c%0d", c), day_done, (c == 6));
         if (c == 5) chk("t4_res_valid", res_valid, 1'b1);
         @(posedge clk); #1;
         ord_valid = 1'b0;
      end
      rq_tag.delete(); rq_succ.delete();
      push(2'd3, 1'b0, 1'b0, 4'd9);
      wait_results(1, 50);
      if (rq_tag.size() > 0) begin
         chk("t4_next_tag", rq_tag[0], 4'd9);
         chk("t4_next_succ", rq_succ[0], 1'b1);
      end
      chk("t4_selling_after", rm_selling, 1'b1);

      // Reset during SEND_P drops the order in flight and the queued one
      repeat (2) @(posedge clk); #1;
      set_ord(2'd0, 1'b0, 1'b0, 4'd3);
      ord_valid = 1'b1;
      @(posedge clk); #1;
      set_ord(2'd1, 1'b1, 1'b0, 4'd4);
      @(posedge clk); #1;
      ord_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t1_in_send_p", rm_in_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t1_in_valid", rm_in_valid, 1'b0);
      chk("t1_selling",  rm_selling,  1'b1);
      chk("t1_ready",    ord_ready,   1'b1);
      chk("t1_proto",    proto_err,   1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      hs = 1'b0;
      repeat (10) begin
         @(negedge clk);
         hs = hs | rm_in_valid | res_valid;
      end
      chk("t1_fifo_empty", hs, 1'b0);
      @(posedge clk); #1;

      // Stock exhaustion: 64 big MISO orders against 63 servings
      do_reset();
      rq_tag.delete(); rq_succ.delete();
      for (int i = 0; i < 64; i++) push(2'd2, 1'b1, 1'b0, TAG_W'(i));
      wait_results(64, 600);
      nsucc = 0;
      foreach (rq_succ[i]) nsucc += int'(rq_succ[i]);
      if (rq_succ.size() == 64) begin
         chk("t5_first_ok", rq_succ[0], 1'b1);
         chk("t5_63_ok", rq_succ[62], 1'b1);
         chk("t5_64_fail", rq_succ[63], 1'b0);
      end
      chk("t5_nsucc", nsucc, 63);
      chk("t5_no_proto", proto_err, 1'b0);

      // Core withholds out_valid_order
      repeat (3) @(posedge clk); #1;
      do_reset();
      faulty = 1'b1;
      set_ord(2'd0, 1'b1, 1'b0, 4'd11);
      ord_valid = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c == 5) begin
            chk("t6_res_valid", res_valid, 1'b1);
            chk("t6_res_succ", res_success, 1'b0);
            chk("t6_proto_pre", proto_err, 1'b0);
         end
         if (c == 6) begin
            chk("t6_proto", proto_err, 1'b1);
            chk("t6_idle_iv", rm_in_valid, 1'b0);
            chk("t6_idle_sell", rm_selling, 1'b1);
            chk("t6_idle_rv", res_valid, 1'b0);
         end
         @(posedge clk); #1;
         ord_valid = 1'b0;
      end
      faulty = 1'b0;
      rq_tag.delete(); rq_succ.delete();
      push(2'd1, 1'b0, 1'b0, 4'd12);
      wait_results(1, 50);
      if (rq_tag.size() > 0) chk("t6_next_tag", rq_tag[0], 4'd12);
      chk("t6_sticky", proto_err, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, %0d checks done", n_tests);
      $fatal(1);
   end
endmodule
